clock_ctrl: RTL

- Top-level sequencer for the digital clock.
- Owns the HH:MM:SS time registers, the 1 Hz prescaler and the run/pause state.
- Runs the time-setting mode state machine, driven by four push-buttons (mode, up, down, play).
- Feeds the display decoders. Replaces ad-hoc per-button toggle logic with one arbitrated controller.

---
 rtl/clock_pkg.sv | 38 +++
 rtl/clock_ctrl_key_conditioner.sv | 55 +++++
 rtl/clock_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types, field encodings and wrap arithmetic for the digital clock controller.
package clock_pkg;

  typedef enum logic [2:0] {
    PAUSE,
    RUN,
    SET_H,
    SET_M,
    SET_S
  } state_t;

  localparam logic [1:0] FIELD_NONE    = 2'd0;
  localparam logic [1:0] FIELD_HOURS   = 2'd1;
  localparam logic [1:0] FIELD_MINUTES = 2'd2;
  localparam logic [1:0] FIELD_SECONDS = 2'd3;

  localparam logic [4:0] HOURS_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [5:0] SEC_MAX   = 6'd59;

  // One step up or down within 0..max_value, wrapping at both ends.
  function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                           input logic [5:0] max_value,
                                           input logic       up);
    if (up) return (value == max_value) ? 6'd0 : value + 6'd1;
    else    return (value == 6'd0) ? max_value : value - 6'd1;
  endfunction

  function automatic logic [1:0] field_of(input state_t state);
    case (state)
      SET_H:   return FIELD_HOURS;
      SET_M:   return FIELD_MINUTES;
      SET_S:   return FIELD_SECONDS;
      default: return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_ctrl_key_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-FF synchronizer, debounce, rising-edge detect.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             meta;
  logic             sync;
  logic [1:0]       fill;
  logic             level;
  logic             level_q;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // A key held through reset must not fire: pulses are enabled only once a
  // genuine low sample has come out of the synchronizer after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      fill    <= 2'b00;
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      meta    <= key;
      sync    <= meta;
      fill    <= {fill[0], 1'b1};
      level_q <= level;
      if (fill[1] && !sync) armed <= 1'b1;
      if (sync != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_q & armed;

endmodule

// File: rtl/clock_ctrl.sv
// Digital clock sequencer: HH:MM:SS registers, 1 Hz prescaler, run/pause and
// time-setting FSM arbitrated from four conditioned push-buttons.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_play,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BLINK_HALF = (CLK_FREQ / 4 > 0) ? CLK_FREQ / 4 : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic mode_p, up_p, down_p, play_p;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .key(key_mode), .pulse(mode_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .key(key_up), .pulse(up_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .reset(reset), .key(key_down), .pulse(down_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
    .clk(clk), .reset(reset), .key(key_play), .pulse(play_p));

  state_t             state, state_n;
  logic [4:0]         hours_n;
  logic [5:0]         minutes_n, seconds_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [BLINK_W-1:0] blink_cnt;
  logic               tick;

  assign tick = (state == RUN) && (presc == PRESC_W'(CLK_FREQ - 1));

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    hours_n   = hours;
    minutes_n = minutes;
    seconds_n = seconds;
    presc_n   = presc;

    if (state == RUN) presc_n = tick ? '0 : presc + PRESC_W'(1);

    if (tick) begin
      if (seconds == SEC_MAX) begin
        seconds_n = '0;
        if (minutes == MIN_MAX) begin
          minutes_n = '0;
          hours_n   = (hours == HOURS_MAX) ? '0 : hours + 5'd1;
        end else begin
          minutes_n = minutes + 6'd1;
        end
      end else begin
        seconds_n = seconds + 6'd1;
      end
    end

    // Mode beats play, play beats up/down; simultaneous up and down cancel.
    if (mode_p) begin
      unique case (state)
        PAUSE, RUN: begin
          state_n = SET_H;
          presc_n = '0;
        end
        SET_H:   state_n = SET_M;
        SET_M:   state_n = SET_S;
        default: state_n = PAUSE;
      endcase
    end else if (play_p) begin
      if (state == RUN)        state_n = PAUSE;
      else if (state == PAUSE) state_n = RUN;
    end else if (up_p ^ down_p) begin
      unique case (state)
        SET_H:   hours_n   = 5'(step_wrap({1'b0, hours}, {1'b0, HOURS_MAX}, up_p));
        SET_M:   minutes_n = step_wrap(minutes, MIN_MAX, up_p);
        SET_S:   seconds_n = step_wrap(seconds, SEC_MAX, up_p);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= PAUSE;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      presc   <= '0;
    end else begin
      state   <= state_n;
      hours   <= hours_n;
      minutes <= minutes_n;
      seconds <= seconds_n;
      presc   <= presc_n;
    end
  end

  // Free-running edit-field flash, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  assign running   = (state == RUN);
  assign field_sel = field_of(state);

endmodule
